sel_debounce_toggle: RTL and testbench
======================================

Name: sel_debounce_toggle

Overview:
- Upstream stage for mux2: turns a raw board push-button into a clean, glitch-free select line.
- Synchronises the button, debounces it with a small FSM and cycle counter, then toggles `sel` on each debounced press.
- `sel` feeds mux2's select input directly; `sel_changed` is a one-cycle pulse for LEDs or logging.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a new level; must be ≥2 (use 4 in sim, ~1_000_000 on board).
- SEL_INIT, 0, value of `sel` after reset and after `sel_clr`.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous push-button, active-high.
- sel_clr  input  1  synchronous request to force `sel` to SEL_INIT.
- sel  output  1  select line to mux2.
- btn_level  output  1  debounced button level.
- sel_changed  output  1  one-cycle pulse when `sel` changes value.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. It is sampled only on `clk` rising edges.
- Reset values: sync flops 0, state LOW, counter 0, `btn_level` 0, `sel` = SEL_INIT, `sel_changed` 0.
- Reset mid-operation:
  - Any pending transition is abandoned.
  - No `sel_changed` pulse occurs on the reset edge or the edge after it.
- Synchroniser: two-flop chain `btn_in` → s1 → s2. Only s2 is used by the FSM.
- FSM states: LOW, RISE_PEND, HIGH, FALL_PEND. Counter width is clog2(DEBOUNCE_CYCLES+1).
  - LOW: if s2=1, go to RISE_PEND with cnt=1; else stay, cnt=0.
  - RISE_PEND, s2=0 (bounce): return to LOW, cnt=0.
  - RISE_PEND, s2=1 and cnt=DEBOUNCE_CYCLES-1: go to HIGH, `btn_level`←1, toggle event.
  - RISE_PEND, otherwise: cnt++.
  - HIGH and FALL_PEND: mirror images of LOW and RISE_PEND.
  - Completing FALL_PEND sets `btn_level`←0. It generates no toggle.
- Latency:
  - `btn_in` rises before edge 0 and is held.
  - s2=1 after edge 1.
  - `btn_level`, `sel` and `sel_changed` update at edge DEBOUNCE_CYCLES+1.
- Glitches: any pulse shorter than DEBOUNCE_CYCLES s2-samples produces no output change.
- Toggle: on the toggle event, `sel`←~`sel` on the same edge as `btn_level`.
- `sel_clr`:
  - Sets `sel`←SEL_INIT on the next edge.
  - Takes priority over a simultaneous toggle event; that toggle is discarded, not deferred.
  - Does not affect the FSM or `btn_level`.
- `sel_changed`: registered; it is 1 for exactly the cycle after an edge where `sel`'s new value differs from its old value. A `sel_clr` while `sel` already equals SEL_INIT produces no pulse.
- Held button: a held button toggles once only. A new toggle requires a debounced release to HIGH→LOW first.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package `sel_pkg`:
  - state encoding localparams: LOW=2'd0, RISE_PEND=2'd1, HIGH=2'd2, FALL_PEND=2'd3;
  - default DEBOUNCE_CYCLES constants for sim and board.
- One sub-module: `sync2` (two-flop synchroniser, with `clk`/`rst`, reset value 0). Reused for other board inputs.

Test Plan (DEBOUNCE_CYCLES=4, SEL_INIT=0):
- Reset: hold `rst` for 3 cycles with `btn_in`=1 → `sel`=0, `btn_level`=0, `sel_changed`=0 throughout. After release, `sel`=1 at edge 5 after the first sampled edge.
- Clean press: `btn_in` 0→1 before edge 0, held for 20 cycles → `btn_level`=1 and `sel`=1 at edge 5, `sel_changed`=1 for that single cycle only. Release for 10 cycles → `btn_level`=0, `sel` stays 1, no pulse.
- Bounce: `btn_in` pattern 1,0,1,1,0,1 (one cycle each), then 0 → `btn_level` and `sel` never change, `sel_changed` never asserts.
- Two presses: press 10 cycles, release 10 cycles, press 10 cycles → `sel` sequence 0→1→0, exactly two `sel_changed` pulses.
- Simultaneous `sel_clr`: assert `sel_clr` on the toggle edge while `sel`=1 → `sel`=0, one pulse. Assert `sel_clr` on the toggle edge while `sel`=0 → `sel` stays 0, no pulse.
- Reset mid-debounce: assert `rst` during RISE_PEND at cnt=2 → state LOW, `sel`=SEL_INIT. With `btn_in` still high, the toggle occurs 5 edges after `rst` deasserts, not earlier.

Source files
------------

// File: rtl/sel_pkg.sv
// Shared definitions for the push-button select path: debounce FSM encoding
// and default debounce lengths for simulation and for the board.
package sel_pkg;

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_RISE_PEND = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_PEND = 2'd3;

  typedef enum logic [1:0] {
    LOW       = ST_LOW,
    RISE_PEND = ST_RISE_PEND,
    HIGH      = ST_HIGH,
    FALL_PEND = ST_FALL_PEND
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_SIM   = 4;
  localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;

  // Counter must hold values up to DEBOUNCE_CYCLES-1 with headroom for the limit itself.
  function automatic int deb_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sel_debounce_toggle_sync2.sv
// Two-flop synchroniser for asynchronous board inputs; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sel_debounce_toggle.sv
// Push-button to mux select: synchronise, debounce, and toggle sel on each
// debounced press; sel_changed pulses for one cycle whenever sel flips.
module sel_debounce_toggle
  import sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter bit SEL_INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic sel_clr,
  output logic sel,
  output logic btn_level,
  output logic sel_changed
);

  localparam int CNT_W = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("sel_debounce_toggle: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  logic btn_s2;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (btn_s2)
  );

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level_q, btn_level_d;
  logic             sel_q, sel_d;
  logic             sel_changed_q, sel_changed_d;
  logic             toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOW;
      cnt_q         <= '0;
      btn_level_q   <= 1'b0;
      sel_q         <= SEL_INIT;
      sel_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level_q   <= btn_level_d;
      sel_q         <= sel_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  // A pending state counts consecutive samples of the new level; any sample
  // of the old level is a bounce and drops straight back.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    btn_level_d = btn_level_q;
    toggle      = 1'b0;
    unique case (state_q)
      LOW: begin
        if (btn_s2) begin
          state_d = RISE_PEND;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RISE_PEND: begin
        if (!btn_s2) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HIGH;
          cnt_d       = '0;
          btn_level_d = 1'b1;
          toggle      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!btn_s2) begin
          state_d = FALL_PEND;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      FALL_PEND: begin
        if (btn_s2) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = LOW;
          cnt_d       = '0;
          btn_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear wins over a coincident toggle, and that toggle is simply lost.
  always_comb begin
    sel_d = sel_q;
    if (sel_clr) begin
      sel_d = SEL_INIT;
    end else if (toggle) begin
      sel_d = ~sel_q;
    end
    sel_changed_d = sel_d ^ sel_q;
  end

  assign sel         = sel_q;
  assign btn_level   = btn_level_q;
  assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_sel_debounce_toggle.sv
// Self-checking bench for sel_debounce_toggle with a sample-window reference model.
module tb_sel_debounce_toggle;

  localparam int DC = 4;
  localparam bit SI = 1'b0;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic sel_clr;
  logic sel;
  logic btn_level;
  logic sel_changed;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_s1, m_s2, m_lvl, m_sel, m_chg;
  bit m_hist[$];

  sel_debounce_toggle #(
    .DEBOUNCE_CYCLES (DC),
    .SEL_INIT        (SI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .sel_clr     (sel_clr),
    .sel         (sel),
    .btn_level   (btn_level),
    .sel_changed (sel_changed)
  );

  always #5 clk = ~clk;

  // Level flips once the last DC synchronised samples all disagree with it.
  task automatic model_edge();
    bit samp;
    bit tog;
    bit all_diff;
    bit nsel;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_sel = SI; m_chg = 1'b0;
      m_hist.delete();
    end else begin
      samp = m_s2;
      tog  = 1'b0;
      m_s2 = m_s1;
      m_s1 = btn_in;
      m_hist.push_back(samp);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      if (m_hist.size() == DC) begin
        all_diff = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] == m_lvl) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl = !m_lvl;
          tog   = m_lvl;
          m_hist.delete();
        end
      end
      nsel  = sel_clr ? SI : (tog ? !m_sel : m_sel);
      m_chg = (nsel != m_sel);
      m_sel = nsel;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_in = 1'b0; sel_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    rst = 1'b1; btn_in = 1'b1; sel_clr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp = {1'b0, SI, 1'b0};
      total++;
      if ({btn_level, sel, sel_changed} !== exp) begin
        bad++;
        $display("FAIL reset_hold k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, exp);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {k >= 6, k >= 6, k == 6};
      total++;
      if ({btn_level, sel, sel_changed} !== exp) begin
        bad++;
        $display("FAIL reset_release k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    do_reset();
    step();
    btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = {k >= 6, k >= 6, k == 6};
      total++;
      if ({btn_level, sel, sel_changed} !== exp) begin
        bad++;
        $display("FAIL clean_press k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, exp);
      end
    end
    btn_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = {k < 6, 1'b1, 1'b0};
      total++;
      if ({btn_level, sel, sel_changed} !== exp) begin
        bad++;
        $display("FAIL clean_release k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [6] = '{1, 0, 1, 1, 0, 1};
    do_reset();
    for (int k = 0; k < 18; k++) begin
      btn_in = (k < 6) ? pat[k] : 1'b0;
      step();
      total++;
      if ({btn_level, sel, sel_changed} !== {1'b0, SI, 1'b0}) begin
        bad++;
        $display("FAIL bounce k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, {1'b0, SI, 1'b0});
      end
    end
  endtask

  task automatic test_two_presses();
    int pulses;
    bit seq [$];
    do_reset();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      btn_in = ((k / 10) % 2 == 0);
      step();
      if (sel_changed === 1'b1) begin
        pulses++;
        seq.push_back(sel);
      end
      total++;
      if ({btn_level, sel, sel_changed} !== {m_lvl, m_sel, m_chg}) begin
        bad++;
        $display("FAIL two_presses_cycle k=%0d got=%b want=%b", k, {btn_level, sel, sel_changed}, {m_lvl, m_sel, m_chg});
      end
    end
    total++;
    if (pulses != 2 || seq.size() != 2 || seq[0] != 1'b1 || seq[1] != 1'b0 || sel !== 1'b0) begin
      bad++;
      $display("FAIL two_presses_seq got pulses=%0d final_sel=%b want pulses=2 seq 1,0 final 0", pulses, sel);
    end
  endtask

  task automatic test_sel_clr();
    logic [2:0] exp;
    do_reset();
    // clear on the toggle edge while sel is already at its initial value
    btn_in = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    sel_clr = 1'b1;
    step();
    sel_clr = 1'b0;
    total++;
    if ({btn_level, sel, sel_changed} !== 3'b100) begin
      bad++;
      $display("FAIL clr_at_init got lvl/sel/chg=%b want=100", {btn_level, sel, sel_changed});
    end
    step();
    total++;
    if ({btn_level, sel, sel_changed} !== 3'b100) begin
      bad++;
      $display("FAIL clr_no_deferred got lvl/sel/chg=%b want=100", {btn_level, sel, sel_changed});
    end
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) step();
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) step();
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) step();
    total++;
    if (sel !== 1'b1) begin
      bad++;
      $display("FAIL clr_setup got sel=%b want=1", sel);
    end
    // clear on the toggle edge while sel is set
    btn_in = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    sel_clr = 1'b1;
    step();
    sel_clr = 1'b0;
    exp = 3'b101;
    total++;
    if ({btn_level, sel, sel_changed} !== exp) begin
      bad++;
      $display("FAIL clr_at_one got lvl/sel/chg=%b want=%b", {btn_level, sel, sel_changed}, exp);
    end
    step();
    total++;
    if ({btn_level, sel, sel_changed} !== 3'b100) begin
      bad++;
      $display("FAIL clr_pulse_len got lvl/sel/chg=%b want=100", {btn_level, sel, sel_changed});
    end
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) step();
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    do_reset();
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) step();
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) step();
    btn_in = 1'b1;
    for (int k = 0; k < 4; k++) step();
    total++;
    if ({btn_level, sel} !== 2'b01) begin
      bad++;
      $display("FAIL mid_setup got lvl/sel=%b want=01", {btn_level, sel});
    end
    rst = 1'b1;
    step();
    total++;
    if ({btn_level, sel, sel_changed} !== {1'b0, SI, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_edge got lvl/sel/chg=%b want=%b", {btn_level, sel, sel_changed}, {1'b0, SI, 1'b0});
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {k >= 6, k >= 6, k == 6};
      total++;
      if ({btn_level, sel, sel_changed} !== exp) begin
        bad++;
        $display("FAIL mid_restart k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, exp);
      end
    end
  endtask

  task automatic test_random();
    int run;
    do_reset();
    run = 0;
    for (int k = 0; k < 3000; k++) begin
      if (run == 0) begin
        btn_in = 1'($urandom_range(0, 1));
        run    = $urandom_range(1, 9);
      end
      run--;
      sel_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      step();
      total++;
      if ({btn_level, sel, sel_changed} !== {m_lvl, m_sel, m_chg}) begin
        bad++;
        $display("FAIL random k=%0d got lvl/sel/chg=%b want=%b", k, {btn_level, sel, sel_changed}, {m_lvl, m_sel, m_chg});
      end
    end
    rst = 1'b0; sel_clr = 1'b0; btn_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_in = 1'b0; sel_clr = 1'b0;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_presses();
    test_sel_clr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
